// File: rtl/x68k_ldr_sink_if.sv
// Loader byte handshake plus SDRAM word-write port of the HPS download sink.
interface x68k_ldr_sink_if #(
  parameter int unsigned ADDR_W = 23
);
  logic              ldr_aen;
  logic [19:0]       ldr_addr;
  logic [7:0]        ldr_wdat;
  logic              ldr_wr;
  logic              ldr_ack;
  logic              ram_req;
  logic              ram_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdat;
  logic [1:0]        ram_be;

  // Sink side: responds to the loader, requests on the SDRAM port.
  modport slave (
    input  ldr_aen, ldr_addr, ldr_wdat, ldr_wr, ram_ack,
    output ldr_ack, ram_req, ram_addr, ram_wdat, ram_be
  );

  // Environment side: loader initiator and SDRAM responder.
  modport master (
    output ldr_aen, ldr_addr, ldr_wdat, ldr_wr, ram_ack,
    input  ldr_ack, ram_req, ram_addr, ram_wdat, ram_be
  );
endinterface

// File: rtl/x68k_ldr_sink.sv
// HPS loader sink: packs even/odd download bytes into 68000-order words and
// writes them to SDRAM through a req/ack port before acknowledging the loader.
module x68k_ldr_sink #(
  parameter int unsigned       ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] BASE_WADDR = ADDR_W'(23'h7F0000)
) (
  input  logic               sysclk,
  input  logic               rstn,
  x68k_ldr_sink_if.slave     bus,
  output logic               busy,
  output logic [19:0]        words_written
);
  localparam int unsigned WA_W  = 19;
  localparam int unsigned CNT_W = 20;

  typedef enum logic [1:0] {IDLE, FLUSH, WRITE, ACK} state_t;

  state_t              state_q, state_d;
  logic                armed_q, armed_d;
  logic                hold_v_q, hold_v_d;
  logic [WA_W-1:0]     hold_wa_q, hold_wa_d;
  logic                hold_lane_q, hold_lane_d;
  logic [7:0]          hold_byte_q, hold_byte_d;
  logic                pend_v_q, pend_v_d;
  logic [WA_W-1:0]     pend_wa_q, pend_wa_d;
  logic                pend_lane_q, pend_lane_d;
  logic [7:0]          pend_byte_q, pend_byte_d;
  logic                ram_req_q, ram_req_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [15:0]         ram_wdat_q, ram_wdat_d;
  logic [1:0]          ram_be_q, ram_be_d;
  logic                ldr_ack_q, ldr_ack_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    ww_q, ww_d;

  logic                accept;
  logic                take;
  logic [WA_W-1:0]     cur_wa;
  logic                cur_lane;
  logic [7:0]          cur_byte;
  logic [15:0]         flush_wdat;
  logic [1:0]          flush_be;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [WA_W-1:0] wa);
    return BASE_WADDR + ADDR_W'(wa);
  endfunction

  // Single-lane write of whatever sits in the buffer.
  assign flush_wdat = hold_lane_q ? {8'h00, hold_byte_q} : {hold_byte_q, 8'h00};
  assign flush_be   = hold_lane_q ? 2'b01 : 2'b10;

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    hold_v_d    = hold_v_q;
    hold_wa_d   = hold_wa_q;
    hold_lane_d = hold_lane_q;
    hold_byte_d = hold_byte_q;
    pend_v_d    = pend_v_q;
    pend_wa_d   = pend_wa_q;
    pend_lane_d = pend_lane_q;
    pend_byte_d = pend_byte_q;
    ram_req_d   = ram_req_q;
    ram_addr_d  = ram_addr_q;
    ram_wdat_d  = ram_wdat_q;
    ram_be_d    = ram_be_q;
    ldr_ack_d   = 1'b0;
    ww_d        = ww_q;
    accept      = 1'b0;
    take        = 1'b0;
    cur_wa      = bus.ldr_addr[19:1];
    cur_lane    = bus.ldr_addr[0];
    cur_byte    = bus.ldr_wdat;

    if (!bus.ldr_wr) armed_d = 1'b1;
    if (ram_req_q && bus.ram_ack && (ww_q != '1)) ww_d = ww_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        accept = bus.ldr_wr && armed_q && bus.ldr_aen && !pend_v_q;
        if (accept) armed_d = 1'b0;
        // A byte parked behind a flush is re-evaluated before anything new.
        if (pend_v_q) begin
          cur_wa   = pend_wa_q;
          cur_lane = pend_lane_q;
          cur_byte = pend_byte_q;
        end
        take = pend_v_q || accept;
        if (take) begin
          pend_v_d = 1'b0;
          if (!cur_lane && !hold_v_q) begin
            hold_v_d    = 1'b1;
            hold_wa_d   = cur_wa;
            hold_lane_d = cur_lane;
            hold_byte_d = cur_byte;
            ldr_ack_d   = 1'b1;
          end else if (cur_lane && hold_v_q && !hold_lane_q && (hold_wa_q == cur_wa)) begin
            ram_req_d  = 1'b1;
            ram_addr_d = word_addr(cur_wa);
            ram_wdat_d = {hold_byte_q, cur_byte};
            ram_be_d   = 2'b11;
            hold_v_d   = 1'b0;
            state_d    = WRITE;
          end else if (hold_v_q) begin
            ram_req_d   = 1'b1;
            ram_addr_d  = word_addr(hold_wa_q);
            ram_wdat_d  = flush_wdat;
            ram_be_d    = flush_be;
            pend_v_d    = 1'b1;
            pend_wa_d   = cur_wa;
            pend_lane_d = cur_lane;
            pend_byte_d = cur_byte;
            state_d     = FLUSH;
          end else begin
            ram_req_d  = 1'b1;
            ram_addr_d = word_addr(cur_wa);
            ram_wdat_d = {8'h00, cur_byte};
            ram_be_d   = 2'b01;
            state_d    = WRITE;
          end
        end else if (!bus.ldr_aen && hold_v_q) begin
          ram_req_d  = 1'b1;
          ram_addr_d = word_addr(hold_wa_q);
          ram_wdat_d = flush_wdat;
          ram_be_d   = flush_be;
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.ram_ack) begin
          ram_req_d = 1'b0;
          hold_v_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        if (bus.ram_ack) begin
          ram_req_d = 1'b0;
          ldr_ack_d = 1'b1;
          state_d   = ACK;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = hold_v_d || pend_v_d || ram_req_d;
  end

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      armed_q     <= 1'b1;
      hold_v_q    <= 1'b0;
      hold_wa_q   <= '0;
      hold_lane_q <= 1'b0;
      hold_byte_q <= '0;
      pend_v_q    <= 1'b0;
      pend_wa_q   <= '0;
      pend_lane_q <= 1'b0;
      pend_byte_q <= '0;
      ram_req_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdat_q  <= '0;
      ram_be_q    <= '0;
      ldr_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      ww_q        <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      hold_v_q    <= hold_v_d;
      hold_wa_q   <= hold_wa_d;
      hold_lane_q <= hold_lane_d;
      hold_byte_q <= hold_byte_d;
      pend_v_q    <= pend_v_d;
      pend_wa_q   <= pend_wa_d;
      pend_lane_q <= pend_lane_d;
      pend_byte_q <= pend_byte_d;
      ram_req_q   <= ram_req_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdat_q  <= ram_wdat_d;
      ram_be_q    <= ram_be_d;
      ldr_ack_q   <= ldr_ack_d;
      busy_q      <= busy_d;
      ww_q        <= ww_d;
    end
  end

  assign bus.ldr_ack    = ldr_ack_q;
  assign bus.ram_req    = ram_req_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdat   = ram_wdat_q;
  assign bus.ram_be     = ram_be_q;
  assign busy           = busy_q;
  assign words_written  = ww_q;
endmodule

// File: tb/tb_x68k_ldr_sink.sv
// Bench for x68k_ldr_sink: directed download scenarios plus a random byte stream,
// checked against a byte-level model of the word packing rules.
module tb_x68k_ldr_sink;
  localparam int unsigned       ADDR_W = 23;
  localparam logic [ADDR_W-1:0] BASE   = 23'h7F0000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdat;
    logic [1:0]        be;
  } wr_t;

  logic        sysclk = 1'b0;
  logic        rstn   = 1'b0;
  logic        busy;
  logic [19:0] words_written;

  x68k_ldr_sink_if #(.ADDR_W(ADDR_W)) bus ();

  x68k_ldr_sink #(.ADDR_W(ADDR_W), .BASE_WADDR(BASE)) dut (
    .sysclk        (sysclk),
    .rstn          (rstn),
    .bus           (bus),
    .busy          (busy),
    .words_written (words_written)
  );

  always #5 sysclk = ~sysclk;

  int          n_assert = 0;
  int          n_fail   = 0;
  wr_t         exp_q[$];
  logic        m_hold_v = 1'b0;
  logic [18:0] m_hold_wa = '0;
  logic [7:0]  m_hold_byte = '0;
  int          m_words = 0;
  logic        req_open = 1'b0;
  logic        acked_last = 1'b0;
  wr_t         cur_wr;
  int          lat = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input logic [18:0] wa, input logic [15:0] wd, input logic [1:0] be);
    wr_t r;
    r.addr = BASE + ADDR_W'(wa);
    r.wdat = wd;
    r.be   = be;
    return r;
  endfunction

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic exp_push(input wr_t w);
    exp_q.push_back(w);
    m_words++;
  endtask

  // Word-packing rules at byte granularity: which RAM writes one byte causes.
  task automatic model_byte(input logic [19:0] a, input logic [7:0] d);
    logic [18:0] wa;
    wa = a[19:1];
    if (!a[0]) begin
      if (m_hold_v) exp_push(mk(m_hold_wa, {m_hold_byte, 8'h00}, 2'b10));
      m_hold_v    = 1'b1;
      m_hold_wa   = wa;
      m_hold_byte = d;
    end else if (m_hold_v && m_hold_wa == wa) begin
      exp_push(mk(wa, {m_hold_byte, d}, 2'b11));
      m_hold_v = 1'b0;
    end else begin
      if (m_hold_v) exp_push(mk(m_hold_wa, {m_hold_byte, 8'h00}, 2'b10));
      exp_push(mk(wa, {8'h00, d}, 2'b01));
      m_hold_v = 1'b0;
    end
  endtask

  // SDRAM responder, one call per negedge: checks each request and acks it after a random delay.
  task automatic ram_cycle(input int lat_min, input int lat_max);
    wr_t e;
    wr_t now;
    bus.ram_ack = 1'b0;
    now = {bus.ram_addr, bus.ram_wdat, bus.ram_be};
    if (acked_last) begin
      chk("req_drop_after_ack", 64'(bus.ram_req), 64'(0));
      acked_last = 1'b0;
    end else if (bus.ram_req) begin
      if (!req_open) begin
        req_open = 1'b1;
        cur_wr   = now;
        lat      = int'($urandom_range(lat_max, lat_min));
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(now), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(now.addr), 64'(e.addr));
          chk("wr_be", 64'(now.be), 64'(e.be));
          chk("wr_wdat", 64'(now.wdat & lane_mask(e.be)), 64'(e.wdat & lane_mask(e.be)));
        end
      end else begin
        chk("req_stable", 64'(now), 64'(cur_wr));
      end
      if (lat == 0) begin
        bus.ram_ack = 1'b1;
        req_open    = 1'b0;
        acked_last  = 1'b1;
      end else begin
        lat--;
      end
    end
  endtask

  task automatic send_byte(input logic [19:0] a, input logic [7:0] d, input int lat_min,
                           input int lat_max, input int extra_hold);
    int   cyc;
    int   ack_cyc;
    logic buffered_only;
    buffered_only = !a[0] && !m_hold_v;
    model_byte(a, d);
    bus.ldr_addr = a;
    bus.ldr_wdat = d;
    bus.ldr_wr   = 1'b1;
    cyc     = 0;
    ack_cyc = -1;
    while (ack_cyc < 0 && cyc < 200) begin
      @(negedge sysclk);
      cyc++;
      ram_cycle(lat_min, lat_max);
      if (bus.ldr_ack) ack_cyc = cyc;
    end
    chk("ldr_ack_seen", 64'(ack_cyc >= 0), 64'(1));
    if (buffered_only) chk("buffered_ack_latency", 64'(ack_cyc), 64'(1));
    chk("writes_before_ack", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    chk("busy_at_ack", 64'(busy), 64'(m_hold_v));
    for (int i = 0; i < extra_hold; i++) begin
      @(negedge sysclk);
      ram_cycle(lat_min, lat_max);
      chk("held_wr_no_ack", 64'(bus.ldr_ack), 64'(0));
      chk("held_wr_no_req", 64'(bus.ram_req), 64'(0));
    end
    bus.ldr_wr = 1'b0;
    @(negedge sysclk);
    ram_cycle(lat_min, lat_max);
    chk("ack_single_cycle", 64'(bus.ldr_ack), 64'(0));
    chk("words_written", 64'(words_written), 64'(m_words));
  endtask

  // Close the download window; a buffered byte must go out alone with no loader ack.
  task automatic aen_drop(input int lat_max);
    int   cyc;
    logic had;
    had = m_hold_v;
    if (m_hold_v) exp_push(mk(m_hold_wa, {m_hold_byte, 8'h00}, 2'b10));
    m_hold_v    = 1'b0;
    bus.ldr_aen = 1'b0;
    @(negedge sysclk);
    ram_cycle(0, lat_max);
    chk("aen_busy_start", 64'(busy), 64'(had));
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge sysclk);
      cyc++;
      ram_cycle(0, lat_max);
      chk("aen_no_ldr_ack", 64'(bus.ldr_ack), 64'(0));
    end
    chk("aen_busy_fall", 64'(busy), 64'(0));
    chk("aen_flush_done", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    @(negedge sysclk);
    ram_cycle(0, lat_max);
    chk("aen_words", 64'(words_written), 64'(m_words));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] prev;
    logic [19:0] a;
    int          r;
    int          cyc;

    bus.ldr_aen  = 1'b1;
    bus.ldr_addr = '0;
    bus.ldr_wdat = '0;
    bus.ldr_wr   = 1'b0;
    bus.ram_ack  = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_ldr_ack", 64'(bus.ldr_ack), 64'(0));
    chk("rst_ram_req", 64'(bus.ram_req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_words", 64'(words_written), 64'(0));
    chk("rst_ram_bus", 64'({bus.ram_addr, bus.ram_wdat, bus.ram_be}), 64'(0));
    rstn = 1'b1;
    @(negedge sysclk);

    // Even then odd byte of word 0 form one full write.
    send_byte(20'h0, 8'h12, 0, 2, 0);
    send_byte(20'h1, 8'h34, 0, 2, 0);
    chk("t1_words", 64'(words_written), 64'(1));

    // Unpaired even byte is flushed when a different word arrives.
    send_byte(20'h2, 8'hAA, 0, 2, 0);
    send_byte(20'h6, 8'hBB, 0, 2, 0);
    send_byte(20'h7, 8'hCC, 0, 2, 0);

    // Odd byte with nothing buffered goes out alone.
    send_byte(20'h9, 8'h55, 1, 3, 0);

    // Sticky ldr_wr and a slow SDRAM side.
    send_byte(20'hC, 8'h01, 0, 0, 5);
    send_byte(20'hD, 8'h02, 20, 20, 5);

    // Window closes with a byte buffered.
    send_byte(20'hA, 8'h77, 0, 0, 0);
    aen_drop(2);
    bus.ldr_addr = 20'h30;
    bus.ldr_wr   = 1'b1;
    repeat (3) begin
      @(negedge sysclk);
      chk("aen_low_ignore_ack", 64'(bus.ldr_ack), 64'(0));
      chk("aen_low_ignore_req", 64'(bus.ram_req), 64'(0));
    end
    bus.ldr_wr = 1'b0;
    @(negedge sysclk);
    bus.ldr_aen = 1'b1;

    // Random byte stream: mostly sequential, some jumps and window drops.
    prev = 20'h100;
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(9, 0));
      if (r == 0) begin
        aen_drop(3);
        bus.ldr_aen = 1'b1;
      end else begin
        a = (r < 7) ? prev + 20'd1 : 20'($urandom_range(255, 0));
        send_byte(a, 8'($urandom), 0, 3, int'($urandom_range(2, 0)));
        prev = a;
      end
    end
    aen_drop(2);
    bus.ldr_aen = 1'b1;

    // Reset in the middle of a RAM write.
    bus.ldr_addr = 20'h21;
    bus.ldr_wdat = 8'h9A;
    bus.ldr_wr   = 1'b1;
    cyc = 0;
    while (!bus.ram_req && cyc < 10) begin
      @(negedge sysclk);
      cyc++;
    end
    chk("rst_setup_req", 64'(bus.ram_req), 64'(1));
    rstn       = 1'b0;
    bus.ldr_wr = 1'b0;
    @(negedge sysclk);
    chk("midrst_ram_req", 64'(bus.ram_req), 64'(0));
    chk("midrst_ldr_ack", 64'(bus.ldr_ack), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_words", 64'(words_written), 64'(0));
    rstn       = 1'b1;
    m_hold_v   = 1'b0;
    m_words    = 0;
    req_open   = 1'b0;
    acked_last = 1'b0;
    exp_q.delete();
    @(negedge sysclk);
    send_byte(20'h0, 8'h12, 0, 1, 0);
    send_byte(20'h1, 8'h34, 0, 1, 0);
    chk("post_rst_words", 64'(words_written), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
